// File: rtl/ysyx_22050019_ifu.sv
`timescale 1ns/1ps
// ysyx_22050019_ifu: instruction fetch unit sitting in front of the icache.
// Holds the PC, issues one fetch at a time on the icache ar channel, selects
// the 32-bit instruction out of the returned 64-bit beat by pc[2], and hands
// {inst, pc, err} to decode over a valid/ready handshake. Redirects are taken
// in any state; a response that was already in flight when a redirect hit is
// drained and thrown away.
// Ports:
//   clk, rst (async, active-low)
//   ar_valid_o/ar_ready_i/ar_addr_o               icache request channel
//   r_data_valid_i/r_data_ready_o/r_resp_i/r_data_i  icache response channel
//   redirect_valid_i/redirect_pc_i                 branch/jump/trap redirect
//   inst_valid_o/inst_ready_i/inst_o/inst_pc_o/fetch_err_o  decode interface
module ysyx_22050019_ifu #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned INST_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(64'h8000_0000)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  ar_valid_o,
  input  logic                  ar_ready_i,
  output logic [ADDR_WIDTH-1:0] ar_addr_o,
  input  logic                  r_data_valid_i,
  output logic                  r_data_ready_o,
  input  logic [1:0]            r_resp_i,
  input  logic [DATA_WIDTH-1:0] r_data_i,
  input  logic                  redirect_valid_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  output logic                  inst_valid_o,
  input  logic                  inst_ready_i,
  output logic [INST_WIDTH-1:0] inst_o,
  output logic [ADDR_WIDTH-1:0] inst_pc_o,
  output logic                  fetch_err_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_DROP = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [INST_WIDTH-1:0] inst_q, inst_d;
  logic [ADDR_WIDTH-1:0] inst_pc_q, inst_pc_d;
  logic                  err_q, err_d;
  logic                  ar_valid_q, ar_valid_d;
  logic                  r_ready_q, r_ready_d;
  logic                  inst_valid_q, inst_valid_d;

  logic [ADDR_WIDTH-1:0] redirect_pc_c;
  logic [INST_WIDTH-1:0] beat_word_c;

  // Redirect targets are forced to 4-byte alignment.
  assign redirect_pc_c = redirect_pc_i & ~ADDR_WIDTH'(3);
  // Pick the 32-bit half of the aligned beat addressed by pc[2].
  assign beat_word_c   = pc_q[2] ? r_data_i[DATA_WIDTH-1:INST_WIDTH]
                                 : r_data_i[INST_WIDTH-1:0];

  // Next-state, PC and payload update; redirect overrides every pc update.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    err_d     = err_q;

    if (redirect_valid_i) begin
      pc_d = redirect_pc_c;
    end

    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (ar_valid_q && ar_ready_i) begin
          // A request accepted alongside a redirect fetches the old pc.
          state_d = redirect_valid_i ? S_DROP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid_i) begin
          state_d = r_data_valid_i ? S_REQ : S_DROP;
        end else if (r_data_valid_i) begin
          state_d   = S_HOLD;
          inst_d    = beat_word_c;
          inst_pc_d = pc_q;
          err_d     = |r_resp_i;
        end
      end
      S_HOLD: begin
        if (redirect_valid_i) begin
          state_d = S_REQ;
        end else if (inst_valid_q && inst_ready_i) begin
          state_d = S_REQ;
          pc_d    = pc_q + ADDR_WIDTH'(4);
        end
      end
      S_DROP: begin
        if (r_data_valid_i) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase

    ar_valid_d   = (state_d == S_REQ);
    r_ready_d    = (state_d == S_WAIT) || (state_d == S_DROP);
    inst_valid_d = (state_d == S_HOLD);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      inst_q       <= '0;
      inst_pc_q    <= RESET_PC;
      err_q        <= 1'b0;
      ar_valid_q   <= 1'b0;
      r_ready_q    <= 1'b0;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      err_q        <= err_d;
      ar_valid_q   <= ar_valid_d;
      r_ready_q    <= r_ready_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  assign ar_valid_o     = ar_valid_q;
  assign ar_addr_o      = pc_q;
  assign r_data_ready_o = r_ready_q;
  assign inst_valid_o   = inst_valid_q;
  assign inst_o         = inst_q;
  assign inst_pc_o      = inst_pc_q;
  assign fetch_err_o    = err_q;

endmodule

// File: tb/tb_ysyx_22050019_ifu.sv
`timescale 1ns/1ps
// Bench for ysyx_22050019_ifu: directed scenarios plus a randomized run
// against a transaction-level model of the fetch stream.
module tb_ysyx_22050019_ifu;

  localparam logic [63:0] RST_PC = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        ar_valid_o, ar_ready_i;
  logic [63:0] ar_addr_o;
  logic        r_data_valid_i, r_data_ready_o;
  logic [1:0]  r_resp_i;
  logic [63:0] r_data_i;
  logic        redirect_valid_i;
  logic [63:0] redirect_pc_i;
  logic        inst_valid_o, inst_ready_i;
  logic [31:0] inst_o;
  logic [63:0] inst_pc_o;
  logic        fetch_err_o;

  int n_tests = 0;
  int n_fail  = 0;

  ysyx_22050019_ifu dut (
    .clk(clk), .rst(rst),
    .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i), .ar_addr_o(ar_addr_o),
    .r_data_valid_i(r_data_valid_i), .r_data_ready_o(r_data_ready_o),
    .r_resp_i(r_resp_i), .r_data_i(r_data_i),
    .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
    .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i),
    .inst_o(inst_o), .inst_pc_o(inst_pc_o), .fetch_err_o(fetch_err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ar_ready_i       = 1'b0;
    r_data_valid_i   = 1'b0;
    r_resp_i         = 2'b00;
    r_data_i         = '0;
    redirect_valid_i = 1'b0;
    redirect_pc_i    = '0;
    inst_ready_i     = 1'b0;
  endtask

  // Icache side of one fetch: accept the request, wait, return one beat.
  task automatic do_fetch(input logic [63:0] beat, input logic [1:0] resp, input int delay);
    ar_ready_i = 1'b1;
    tick();
    ar_ready_i = 1'b0;
    repeat (delay) tick();
    r_data_valid_i = 1'b1;
    r_data_i       = beat;
    r_resp_i       = resp;
    tick();
    r_data_valid_i = 1'b0;
    r_resp_i       = 2'b00;
  endtask

  task automatic accept();
    inst_ready_i = 1'b1;
    tick();
    inst_ready_i = 1'b0;
  endtask

  // Icache contents as seen by the bench: a fixed function of the aligned address.
  function automatic logic [63:0] mem_beat(input logic [63:0] a);
    logic [63:0] b;
    b = a & ~64'h7;
    return {b[31:0] ^ 32'hDEAD_0003, b[31:0] ^ b[63:32] ^ 32'h0000_5A5B};
  endfunction

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({ar_valid_o, r_data_ready_o, inst_valid_o, fetch_err_o} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ctl: got %b exp 0000", {ar_valid_o, r_data_ready_o, inst_valid_o, fetch_err_o});
    end
    n_tests++;
    if ({ar_addr_o, inst_pc_o, inst_o} !== {RST_PC, RST_PC, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_data: got addr %h pc %h inst %h exp %h %h 0", ar_addr_o, inst_pc_o, inst_o, RST_PC, RST_PC);
    end
    rst = 1'b1;
    tick();
    n_tests++;
    if ({ar_valid_o, ar_addr_o, inst_valid_o} !== {1'b1, RST_PC, 1'b0}) begin
      n_fail++;
      $display("FAIL first_req: got valid %b addr %h ivalid %b exp 1 %h 0", ar_valid_o, ar_addr_o, inst_valid_o, RST_PC);
    end
  endtask

  task automatic test_fetch_order();
    do_fetch(64'h0000_0013_0000_0093, 2'b00, 0);
    n_tests++;
    if ({inst_valid_o, inst_o, inst_pc_o, fetch_err_o} !== {1'b1, 32'h0000_0093, 64'h8000_0000, 1'b0}) begin
      n_fail++;
      $display("FAIL lo_word: got v%b %h @%h e%b exp v1 00000093 @80000000 e0", inst_valid_o, inst_o, inst_pc_o, fetch_err_o);
    end
    accept();
    n_tests++;
    if ({ar_valid_o, ar_addr_o, inst_valid_o} !== {1'b1, 64'h8000_0004, 1'b0}) begin
      n_fail++;
      $display("FAIL pc_advance: got v%b %h iv%b exp v1 80000004 iv0", ar_valid_o, ar_addr_o, inst_valid_o);
    end
    do_fetch(64'h0000_0013_0000_0093, 2'b00, 1);
    n_tests++;
    if ({inst_valid_o, inst_o, inst_pc_o} !== {1'b1, 32'h0000_0013, 64'h8000_0004}) begin
      n_fail++;
      $display("FAIL hi_word: got v%b %h @%h exp v1 00000013 @80000004", inst_valid_o, inst_o, inst_pc_o);
    end
    accept();
  endtask

  task automatic test_stall();
    do_fetch(64'h1111_2222_3333_4444, 2'b00, 1);
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if ({inst_valid_o, inst_o, inst_pc_o, ar_valid_o, ar_addr_o} !==
          {1'b1, 32'h3333_4444, 64'h8000_0008, 1'b0, 64'h8000_0008}) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got v%b %h @%h arv%b pc %h exp v1 33334444 @80000008 arv0 pc 80000008",
                 i, inst_valid_o, inst_o, inst_pc_o, ar_valid_o, ar_addr_o);
      end
      tick();
    end
    accept();
    n_tests++;
    if ({ar_valid_o, ar_addr_o} !== {1'b1, 64'h8000_000C}) begin
      n_fail++;
      $display("FAIL stall_release: got v%b %h exp v1 8000000c", ar_valid_o, ar_addr_o);
    end
  endtask

  task automatic test_redirect();
    ar_ready_i = 1'b1;
    tick();
    ar_ready_i       = 1'b0;
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 64'h8000_0100;
    tick();
    redirect_valid_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if ({inst_valid_o, ar_valid_o, r_data_ready_o} !== 3'b001) begin
        n_fail++;
        $display("FAIL drop_wait[%0d]: got iv%b arv%b rr%b exp iv0 arv0 rr1", i, inst_valid_o, ar_valid_o, r_data_ready_o);
      end
      if (i == 0) tick();
    end
    r_data_valid_i = 1'b1;
    r_data_i       = 64'hAAAA_BBBB_CCCC_DDDD;
    tick();
    r_data_valid_i = 1'b0;
    n_tests++;
    if ({inst_valid_o, ar_valid_o, ar_addr_o} !== {1'b0, 1'b1, 64'h8000_0100}) begin
      n_fail++;
      $display("FAIL drop_done: got iv%b arv%b %h exp iv0 arv1 80000100", inst_valid_o, ar_valid_o, ar_addr_o);
    end
    do_fetch(64'h0000_0001_0000_0002, 2'b00, 2);
    n_tests++;
    if ({inst_valid_o, inst_pc_o, inst_o} !== {1'b1, 64'h8000_0100, 32'h0000_0002}) begin
      n_fail++;
      $display("FAIL redirect_first: got v%b @%h %h exp v1 @80000100 00000002", inst_valid_o, inst_pc_o, inst_o);
    end
    // Redirect in HOLD beats a simultaneous accept; target low bits dropped.
    inst_ready_i     = 1'b1;
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 64'h8000_0202;
    tick();
    inst_ready_i     = 1'b0;
    redirect_valid_i = 1'b0;
    n_tests++;
    if ({inst_valid_o, ar_valid_o, ar_addr_o} !== {1'b0, 1'b1, 64'h8000_0200}) begin
      n_fail++;
      $display("FAIL hold_redirect: got iv%b arv%b %h exp iv0 arv1 80000200", inst_valid_o, ar_valid_o, ar_addr_o);
    end
  endtask

  task automatic test_error();
    do_fetch(64'h0000_0073_0000_0067, 2'b10, 0);
    n_tests++;
    if ({inst_valid_o, fetch_err_o, inst_o} !== {1'b1, 1'b1, 32'h0000_0067}) begin
      n_fail++;
      $display("FAIL err_beat: got v%b e%b %h exp v1 e1 00000067", inst_valid_o, fetch_err_o, inst_o);
    end
    accept();
    n_tests++;
    if ({ar_valid_o, ar_addr_o} !== {1'b1, 64'h8000_0204}) begin
      n_fail++;
      $display("FAIL err_no_stall: got v%b %h exp v1 80000204", ar_valid_o, ar_addr_o);
    end
    do_fetch(64'h0000_0073_0000_0067, 2'b00, 0);
    n_tests++;
    if ({inst_valid_o, fetch_err_o, inst_o} !== {1'b1, 1'b0, 32'h0000_0073}) begin
      n_fail++;
      $display("FAIL err_clear: got v%b e%b %h exp v1 e0 00000073", inst_valid_o, fetch_err_o, inst_o);
    end
    accept();
  endtask

  task automatic test_async_reset();
    ar_ready_i = 1'b1;
    tick();
    ar_ready_i = 1'b0;
    n_tests++;
    if (r_data_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_wait: got rr%b exp rr1", r_data_ready_o);
    end
    #2;
    rst = 1'b0;
    #1;
    n_tests++;
    if ({ar_valid_o, r_data_ready_o, inst_valid_o, fetch_err_o, ar_addr_o, inst_pc_o} !==
        {4'b0000, RST_PC, RST_PC}) begin
      n_fail++;
      $display("FAIL areset_now: got %b %h %h exp 0000 %h %h",
               {ar_valid_o, r_data_ready_o, inst_valid_o, fetch_err_o}, ar_addr_o, inst_pc_o, RST_PC, RST_PC);
    end
    rst = 1'b1;
    tick();
    n_tests++;
    if ({ar_valid_o, ar_addr_o} !== {1'b1, RST_PC}) begin
      n_fail++;
      $display("FAIL areset_restart: got v%b %h exp v1 %h", ar_valid_o, ar_addr_o, RST_PC);
    end
  endtask

  // Random icache timing, decode back-pressure and redirects against a
  // model of the architectural fetch stream.
  task automatic test_random();
    logic [63:0] exp_pc, o_addr, p_pc;
    logic        outst, stale, pend, p_err, ar_hs, r_hs, i_hs;
    logic [31:0] p_inst;
    logic [63:0] shifted;
    int          dly;
    exp_pc = RST_PC; o_addr = '0; p_pc = '0; p_inst = '0; p_err = 1'b0;
    outst = 1'b0; stale = 1'b0; pend = 1'b0; dly = 0;
    for (int c = 0; c < 3000; c++) begin
      n_tests++;
      if (inst_valid_o !== pend) begin
        n_fail++;
        if (n_fail <= 20) $display("FAIL rnd_inst_valid c%0d: got %b exp %b", c, inst_valid_o, pend);
      end
      if (pend && inst_valid_o === 1'b1) begin
        n_tests++;
        if ({inst_o, inst_pc_o, fetch_err_o} !== {p_inst, p_pc, p_err}) begin
          n_fail++;
          if (n_fail <= 20) $display("FAIL rnd_payload c%0d: got %h @%h e%b exp %h @%h e%b",
                                     c, inst_o, inst_pc_o, fetch_err_o, p_inst, p_pc, p_err);
        end
      end
      n_tests++;
      if (ar_valid_o !== (!outst && !pend)) begin
        n_fail++;
        if (n_fail <= 20) $display("FAIL rnd_ar_valid c%0d: got %b exp %b", c, ar_valid_o, !outst && !pend);
      end
      n_tests++;
      if (r_data_ready_o !== outst) begin
        n_fail++;
        if (n_fail <= 20) $display("FAIL rnd_r_ready c%0d: got %b exp %b", c, r_data_ready_o, outst);
      end

      ar_ready_i       = 1'($urandom_range(0, 1));
      inst_ready_i     = 1'($urandom_range(0, 1));
      redirect_valid_i = ($urandom_range(0, 11) == 0);
      case ($urandom_range(0, 3))
        0:       redirect_pc_i = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
        1:       redirect_pc_i = {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_0FFF)};
        default: redirect_pc_i = {32'($urandom), 32'($urandom)};
      endcase
      if (outst && dly == 0) begin
        r_data_valid_i = 1'b1;
        r_data_i       = mem_beat(o_addr);
        r_resp_i       = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      end else begin
        r_data_valid_i = 1'b0;
        r_data_i       = {32'($urandom), 32'($urandom)};
        r_resp_i       = 2'($urandom_range(0, 3));
      end

      ar_hs = ar_valid_o && ar_ready_i;
      r_hs  = r_data_valid_i && r_data_ready_o;
      i_hs  = inst_valid_o && inst_ready_i;
      if (outst && dly > 0) dly--;
      if (r_hs) begin
        outst = 1'b0;
        if (!stale && !redirect_valid_i) begin
          pend    = 1'b1;
          shifted = r_data_i >> (o_addr[2] ? 32 : 0);
          p_inst  = shifted[31:0];
          p_pc    = o_addr;
          p_err   = (r_resp_i != 2'b00);
        end
      end
      if (i_hs && !redirect_valid_i) begin
        exp_pc = exp_pc + 64'd4;
        pend   = 1'b0;
      end
      if (ar_hs) begin
        n_tests++;
        if (ar_addr_o !== exp_pc) begin
          n_fail++;
          if (n_fail <= 20) $display("FAIL rnd_ar_addr c%0d: got %h exp %h", c, ar_addr_o, exp_pc);
        end
        outst  = 1'b1;
        o_addr = exp_pc;
        stale  = 1'b0;
        dly    = $urandom_range(0, 3);
      end
      if (redirect_valid_i) begin
        exp_pc = redirect_pc_i & ~64'h3;
        stale  = 1'b1;
        pend   = 1'b0;
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_fetch_order();
    test_stall();
    test_redirect();
    test_error();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
